// File: rtl/jtframe_dual_ram_clr_if.sv
// Bus bundle for the clearable dual-port RAM: two read/write ports plus the busy flag.
interface jtframe_dual_ram_clr_if #(
  parameter int dw = 8,
  parameter int aw = 10
);
  logic [dw-1:0] data0;
  logic [aw-1:0] addr0;
  logic          we0;
  logic [dw-1:0] q0;
  logic [dw-1:0] data1;
  logic [aw-1:0] addr1;
  logic          we1;
  logic [dw-1:0] q1;
  logic          busy;

  modport master (
    output data0, addr0, we0, data1, addr1, we1,
    input  q0, q1, busy
  );

  modport slave (
    input  data0, addr0, we0, data1, addr1, we1,
    output q0, q1, busy
  );
endinterface

// File: rtl/jtframe_dual_ram_clr.sv
// True dual-port RAM with registered read-first outputs and a post-reset clear sweep
// that fills every word with CLR_VAL before user accesses are accepted.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_CLEAR | sweeping word cnt to CLR_VAL; user accesses ignored, q = 0
// ST_RUN   | normal dual-port access
module jtframe_dual_ram_clr #(
  parameter int dw      = 8,
  parameter int aw      = 10,
  parameter int CLR_VAL = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  jtframe_dual_ram_clr_if.slave    bus
);

  localparam logic [dw-1:0] CLR_WORD = dw'(CLR_VAL);
  localparam logic [aw-1:0] LAST     = '1;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t        state, state_nx;
  logic [aw-1:0] cnt, cnt_nx;
  logic          clr_we, wr0, wr1;
  logic [dw-1:0] q0, q1;
  logic [dw-1:0] mem [0:(1<<aw)-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Busy drops on the same edge that writes the last word; the counter wraps to 0 there.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    clr_we   = 1'b0;
    wr0      = 1'b0;
    wr1      = 1'b0;
    case (state)
      ST_CLEAR: begin
        clr_we = 1'b1;
        cnt_nx = cnt + 1'b1;
        if (cnt == LAST) state_nx = ST_RUN;
      end
      ST_RUN: begin
        wr0 = bus.we0;
        wr1 = bus.we1;
      end
      default: state_nx = ST_CLEAR;
    endcase
  end

  // Port 1 is written first so a same-address port 0 write overrides it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we) begin
        mem[cnt] <= CLR_WORD;
      end else begin
        if (wr1) mem[bus.addr1] <= bus.data1;
        if (wr0) mem[bus.addr0] <= bus.data0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || state != ST_RUN) begin
      q0 <= '0;
      q1 <= '0;
    end else begin
      q0 <= mem[bus.addr0];
      q1 <= mem[bus.addr1];
    end
  end

  assign bus.q0   = q0;
  assign bus.q1   = q1;
  assign bus.busy = (state == ST_CLEAR);

endmodule

// File: tb/tb_jtframe_dual_ram_clr.sv
// Self-checking bench for jtframe_dual_ram_clr (aw=4, dw=8, CLR_VAL=8'h0F) using a
// reference model whose per-cycle expectations go through a scoreboard queue.
module tb_jtframe_dual_ram_clr;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  jtframe_dual_ram_clr_if #(.dw(8), .aw(4)) bus ();

  jtframe_dual_ram_clr #(.dw(8), .aw(4), .CLR_VAL(8'h0F)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [7:0] q0;
    logic [7:0] q1;
    logic       busy;
  } exp_t;

  exp_t       sb [$];
  logic [7:0] m_mem [0:15];
  logic [3:0] m_cnt;
  logic       m_busy;
  logic [7:0] o0, o1;
  logic       ob;
  int         n;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, predict outputs, compare after the edge.
  task automatic step(input logic r, input logic w0, input logic [3:0] a0, input logic [7:0] d0,
                      input logic w1, input logic [3:0] a1, input logic [7:0] d1,
                      output logic [7:0] g0, output logic [7:0] g1, output logic gb);
    exp_t e;
    rst = r;
    bus.we0 = w0; bus.addr0 = a0; bus.data0 = d0;
    bus.we1 = w1; bus.addr1 = a1; bus.data1 = d1;
    if (r) begin
      e = '{q0: 8'h00, q1: 8'h00, busy: 1'b1};
      m_busy = 1'b1;
      m_cnt  = 4'd0;
    end else if (m_busy) begin
      m_mem[m_cnt] = 8'h0F;
      e = '{q0: 8'h00, q1: 8'h00, busy: (m_cnt != 4'd15)};
      m_busy = e.busy;
      m_cnt  = 4'(m_cnt + 4'd1);
    end else begin
      e = '{q0: m_mem[a0], q1: m_mem[a1], busy: 1'b0};
      if (w1) m_mem[a1] = d1;
      if (w0) m_mem[a0] = d0;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    g0 = bus.q0;
    g1 = bus.q1;
    gb = bus.busy;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("q0", 32'(g0), 32'(e.q0));
      chk("q1", 32'(g1), 32'(e.q1));
      chk("busy", 32'(gb), 32'(e.busy));
    end
  endtask

  task automatic rd(input logic [3:0] a0, input logic [3:0] a1);
    step(1'b0, 1'b0, a0, 8'h00, 1'b0, a1, 8'h00, o0, o1, ob);
  endtask

  // Runs released cycles with write attempts on both ports until busy falls.
  task automatic sweep_len(output int len);
    len = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, 4'd1, 8'hFF, 1'b1, 4'd1, 8'hEE, o0, o1, ob);
      len++;
      chk("sweep_q0", 32'(o0), 32'd0);
      if (!ob) break;
    end
  endtask

  initial begin
    bus.we0 = 1'b0; bus.addr0 = '0; bus.data0 = '0;
    bus.we1 = 1'b0; bus.addr1 = '0; bus.data1 = '0;

    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 4'd1, 8'hFF, 1'b0, 4'd0, 8'h00, o0, o1, ob);
      chk("rst_busy", 32'(ob), 32'd1);
    end

    sweep_len(n);
    chk("busy_len", 32'(n), 32'd16);

    for (int i = 0; i < 16; i++) begin
      rd(4'd0, 4'(i));
      chk("clr_val", 32'(o1), 32'h0F);
    end

    step(1'b0, 1'b1, 4'd3, 8'hA5, 1'b0, 4'd3, 8'h00, o0, o1, ob);
    chk("xport_rfirst", 32'(o1), 32'h0F);
    rd(4'd0, 4'd3);
    chk("rd_lat", 32'(o1), 32'hA5);

    step(1'b0, 1'b1, 4'd5, 8'h11, 1'b0, 4'd0, 8'h00, o0, o1, ob);
    step(1'b0, 1'b1, 4'd5, 8'h22, 1'b0, 4'd0, 8'h00, o0, o1, ob);
    chk("same_rfirst", 32'(o0), 32'h11);
    rd(4'd5, 4'd0);
    chk("same_new", 32'(o0), 32'h22);

    step(1'b0, 1'b1, 4'd7, 8'hAA, 1'b1, 4'd7, 8'h55, o0, o1, ob);
    rd(4'd7, 4'd7);
    chk("collide0", 32'(o0), 32'hAA);
    chk("collide1", 32'(o1), 32'hAA);

    step(1'b0, 1'b1, 4'd2, 8'h01, 1'b1, 4'd9, 8'h02, o0, o1, ob);
    rd(4'd2, 4'd9);
    chk("dual_wr0", 32'(o0), 32'h01);
    chk("dual_wr1", 32'(o1), 32'h02);

    for (int i = 0; i < 150; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom), o0, o1, ob);
    end

    step(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, o0, o1, ob);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 4'd1, 8'hFF, 1'b1, 4'd4, 8'h33, o0, o1, ob);
      chk("mid_busy", 32'(ob), 32'd1);
    end
    step(1'b1, 1'b1, 4'd1, 8'hFF, 1'b0, 4'd0, 8'h00, o0, o1, ob);
    sweep_len(n);
    chk("restart_len", 32'(n), 32'd16);
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), 4'(15 - i));
      chk("reclr0", 32'(o0), 32'h0F);
      chk("reclr1", 32'(o1), 32'h0F);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jtframe_dual_ram_clr.md
Name: jtframe_dual_ram_clr

Overview:
- Single-clock, true dual-port synchronous RAM for line/object buffers (e.g. a two-line sprite buffer: port 0 writes new pixels, port 1 reads old ones and blanks them).
- Two independent read/write ports with registered outputs.
- Adds a synchronous reset that clears the output registers, then sweeps the whole array to a programmable clear value before normal access is accepted.

Parameters:
- dw, 8, data width in bits
- aw, 10, address width in bits; depth = 2^aw words
- CLR_VAL, 0, value written to every word during the post-reset clear sweep (low dw bits used)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous active-high reset
- data0  in  dw  port 0 write data
- addr0  in  aw  port 0 address
- we0  in  1  port 0 write enable
- q0  out  dw  port 0 registered read data
- data1  in  dw  port 1 write data
- addr1  in  aw  port 1 address
- we1  in  1  port 1 write enable
- q1  out  dw  port 1 registered read data
- busy  out  1  high while reset is held or the clear sweep is running; user accesses are ignored

Behaviour:
- Reset, sampled on the rising edge with rst=1:
  - q0=0, q1=0, busy=1.
  - Sweep counter = 0.
  - No array writes occur while rst is high.
- Clear sweep: in the k-th cycle after rst falls (k=0..2^aw-1), word k is written with CLR_VAL[dw-1:0].
  - busy is registered and falls on the edge that writes word 2^aw-1.
  - busy is therefore 0 from cycle 2^aw onward.
  - The sweep counter wraps to 0 and stops.
- During busy:
  - we0 and we1 are ignored.
  - q0 and q1 hold 0.
  - addr and data inputs are don't-care.
- Reassertion of rst mid-sweep restarts the sweep from address 0 after release.
- Normal read:
  - qN updates every cycle to mem[addrN] as it was before that edge.
  - Latency is 1 clock: addr presented at edge t, data on qN after edge t.
  - There is no read enable.
- Normal write: weN=1 at an edge stores dataN at addrN on that edge.
- Same-port read-during-write is read-first: qN shows the old word, and the new word is visible from the next cycle.
- Cross-port read-during-write is also read-first: port A reading the address port B writes in the same cycle gets the old data.
- Write collision: we0=we1=1 with addr0==addr1 stores data0 (port 0 has priority).
- Both ports may write different addresses in the same cycle; both writes take effect.
- Addresses are full-range; there are no out-of-range cases.
- No X propagation after the sweep: every word is defined.

Test Plan:
- Reset/clear (aw=4, dw=8, CLR_VAL=8'h0F):
  - Drive rst=1 for 3 cycles, then release.
  - busy stays 1 for exactly 16 cycles after release, then 0.
  - Reading all 16 addresses on port 1 returns 8'h0F, each one cycle after its address.
- Write/read latency:
  - Write 8'hA5 to addr0=3 via port 0, then read addr1=3 on port 1.
  - q1=8'hA5 one clock after addr1 is presented.
  - Same-cycle read on port 1 of addr 3 during the write returns the old value 8'h0F.
- Read-first same port:
  - mem[5]=8'h11; write 8'h22 to addr0=5 with we0=1.
  - q0=8'h11 that cycle, then q0=8'h22 on the next cycle with we0=0.
- Collision:
  - we0=we1=1, addr0=addr1=7, data0=8'hAA, data1=8'h55.
  - A subsequent read of address 7 returns 8'hAA.
- Dual independent writes:
  - Port 0 writes 8'h01 to addr 2 while port 1 writes 8'h02 to addr 9 in the same cycle.
  - Reads return 8'h01 and 8'h02 respectively.
- Busy gating and mid-sweep reset:
  - Assert we0=1, data0=8'hFF, addr0=1 during busy; after the sweep, addr 1 reads CLR_VAL.
  - Pulse rst at sweep cycle 6: busy stays 1 for a further 16 cycles after release, and q0/q1 read 0 throughout.
